// File: rtl/ifu_inst_queue.sv
// -----------------------------------------------------------------------------
// ifu_inst_queue
//
// Instruction fetch queue sitting directly behind the 4-wide IFU. Each cycle it
// accepts up to four in-order instructions {inst, pc, pred} from fetch and
// presents the four oldest entries, in program order, to decode. The queue
// absorbs fetch bursts while decode stalls and is emptied on a mispredict or
// icache redirect.
//
// Ports
//   clock                   rising-edge clock
//   reset                   synchronous, active-high reset (priority over flush)
//   flush                   synchronous clear; blocks enqueue/dequeue this cycle
//   in_valid[3:0]           IFU lane valid, lane 0 oldest
//   in_ready[3:0]           per-lane accept back to the IFU
//   inst1_i..inst4_i        instruction words, lanes 0..3
//   pc1_i..pc4_i            lane PCs
//   pred1_i..pred4_i        predicted-taken bits
//   out_valid[3:0]          entry head+k is present on decode lane k
//   out_ready[3:0]          decode accept per lane
//   inst1_o..inst4_o        instruction of entry head+k
//   pc1_o..pc4_o            PC of entry head+k
//   pred1_o..pred4_o        prediction bit of entry head+k
//   count                   current occupancy, 0..DEPTH
//
// Optional build macro: IFU_INST_QUEUE_PERF_EN
//   Adds perf_full_cycles / perf_empty_cycles, 32-bit saturating event
//   counters that are cleared by reset only (flush leaves them alone).
// -----------------------------------------------------------------------------
module ifu_inst_queue #(
    parameter int DEPTH      = 16,   // power of two, >= 8
    parameter int ADDR_WIDTH = 32
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    flush,

    input  logic [3:0]              in_valid,
    output logic [3:0]              in_ready,
    input  logic [31:0]             inst1_i,
    input  logic [31:0]             inst2_i,
    input  logic [31:0]             inst3_i,
    input  logic [31:0]             inst4_i,
    input  logic [ADDR_WIDTH-1:0]   pc1_i,
    input  logic [ADDR_WIDTH-1:0]   pc2_i,
    input  logic [ADDR_WIDTH-1:0]   pc3_i,
    input  logic [ADDR_WIDTH-1:0]   pc4_i,
    input  logic                    pred1_i,
    input  logic                    pred2_i,
    input  logic                    pred3_i,
    input  logic                    pred4_i,

    output logic [3:0]              out_valid,
    input  logic [3:0]              out_ready,
    output logic [31:0]             inst1_o,
    output logic [31:0]             inst2_o,
    output logic [31:0]             inst3_o,
    output logic [31:0]             inst4_o,
    output logic [ADDR_WIDTH-1:0]   pc1_o,
    output logic [ADDR_WIDTH-1:0]   pc2_o,
    output logic [ADDR_WIDTH-1:0]   pc3_o,
    output logic [ADDR_WIDTH-1:0]   pc4_o,
    output logic                    pred1_o,
    output logic                    pred2_o,
    output logic                    pred3_o,
    output logic                    pred4_o,

`ifdef IFU_INST_QUEUE_PERF_EN
    output logic [31:0]             perf_full_cycles,
    output logic [31:0]             perf_empty_cycles,
`endif
    output logic [$clog2(DEPTH):0]  count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int LANES = 4;

    typedef struct packed {
        logic [31:0]           inst;
        logic [ADDR_WIDTH-1:0] pc;
        logic                  pred;
    } entry_t;

    // Number of consecutive ones starting at bit 0. Lanes are strictly in
    // program order, so a hole ends the group even if later lanes are set.
    function automatic logic [2:0] lead_ones(input logic [3:0] v);
        logic [2:0] n;
        n = 3'd0;
        if (v[0]) begin
            n = 3'd1;
            if (v[1]) begin
                n = 3'd2;
                if (v[2]) begin
                    n = v[3] ? 3'd4 : 3'd3;
                end
            end
        end
        return n;
    endfunction

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    entry_t             mem_q [DEPTH];
    logic [PTR_W-1:0]   head_q, head_d;
    logic [PTR_W-1:0]   tail_q, tail_d;
    logic [CNT_W-1:0]   cnt_q,  cnt_d;

    entry_t             wr_entry [LANES];
    entry_t             rd_entry [LANES];
    logic [CNT_W-1:0]   free_slots;
    logic [2:0]         enq_cnt;
    logic [2:0]         deq_cnt;

    assign wr_entry[0] = '{inst: inst1_i, pc: pc1_i, pred: pred1_i};
    assign wr_entry[1] = '{inst: inst2_i, pc: pc2_i, pred: pred2_i};
    assign wr_entry[2] = '{inst: inst3_i, pc: pc3_i, pred: pred3_i};
    assign wr_entry[3] = '{inst: inst4_i, pc: pc4_i, pred: pred4_i};

    // -------------------------------------------------------------------------
    // Handshake and next-state
    // -------------------------------------------------------------------------
    // Readiness is taken from the start-of-cycle occupancy only: space freed by
    // this cycle's dequeue is not offered to this cycle's enqueue, which keeps
    // in_ready off the decode-side out_ready path.
    always_comb begin
        // NOTE: every always_comb output is given a default before any branch,
        // so no path can leave it unassigned and infer a latch.
        free_slots = CNT_W'(DEPTH) - cnt_q;
        in_ready   = '0;
        out_valid  = '0;
        for (int k = 0; k < LANES; k++) begin
            if (!reset && !flush) begin
                in_ready[k]  = free_slots > CNT_W'(k);
                out_valid[k] = cnt_q > CNT_W'(k);
            end
        end

        enq_cnt = lead_ones(in_valid & in_ready);
        deq_cnt = lead_ones(out_valid & out_ready);

        // Pointer arithmetic wraps naturally since DEPTH is a power of two.
        head_d = head_q + PTR_W'(deq_cnt);
        tail_d = tail_q + PTR_W'(enq_cnt);
        cnt_d  = cnt_q + CNT_W'(enq_cnt) - CNT_W'(deq_cnt);

        if (flush) begin
            head_d = '0;
            tail_d = '0;
            cnt_d  = '0;
        end
    end

    always_ff @(posedge clock) begin
        // NOTE: sequential state is updated with non-blocking assignments so
        // every register samples its pre-edge inputs regardless of block order.
        if (reset) begin
            head_q <= '0;
            tail_q <= '0;
            cnt_q  <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            cnt_q  <= cnt_d;
        end
    end

    // -------------------------------------------------------------------------
    // Storage
    // -------------------------------------------------------------------------
    // NOTE: the entry array has no reset; occupancy alone decides which entries
    // are meaningful, and leaving it unreset lets it map onto plain flops/RAM.
    // enq_cnt is already zero while reset or flush is high.
    always_ff @(posedge clock) begin
        for (int k = 0; k < LANES; k++) begin
            if (3'(k) < enq_cnt) begin
                mem_q[tail_q + PTR_W'(k)] <= wr_entry[k];
            end
        end
    end

    // Decode lane k always shows entry head+k; reads wrap across DEPTH-1 -> 0.
    always_comb begin
        for (int k = 0; k < LANES; k++) begin
            rd_entry[k] = mem_q[head_q + PTR_W'(k)];
        end
    end

    assign inst1_o = rd_entry[0].inst;
    assign inst2_o = rd_entry[1].inst;
    assign inst3_o = rd_entry[2].inst;
    assign inst4_o = rd_entry[3].inst;
    assign pc1_o   = rd_entry[0].pc;
    assign pc2_o   = rd_entry[1].pc;
    assign pc3_o   = rd_entry[2].pc;
    assign pc4_o   = rd_entry[3].pc;
    assign pred1_o = rd_entry[0].pred;
    assign pred2_o = rd_entry[1].pred;
    assign pred3_o = rd_entry[2].pred;
    assign pred4_o = rd_entry[3].pred;

    assign count = reset ? '0 : cnt_q;

    // -------------------------------------------------------------------------
    // Optional performance counters
    // -------------------------------------------------------------------------
`ifdef IFU_INST_QUEUE_PERF_EN
    logic [31:0] perf_full_q;
    logic [31:0] perf_empty_q;

    // Full cycles only count when fetch actually has something to deliver.
    always_ff @(posedge clock) begin
        if (reset) begin
            perf_full_q  <= '0;
            perf_empty_q <= '0;
        end else begin
            if (cnt_q == CNT_W'(DEPTH) && in_valid[0] && perf_full_q != '1) begin
                perf_full_q <= perf_full_q + 32'd1;
            end
            if (cnt_q == '0 && !flush && perf_empty_q != '1) begin
                perf_empty_q <= perf_empty_q + 32'd1;
            end
        end
    end

    assign perf_full_cycles  = perf_full_q;
    assign perf_empty_cycles = perf_empty_q;
`endif

    // -------------------------------------------------------------------------
    // Occupancy / pointer consistency
    // -------------------------------------------------------------------------
    invariant_a: assert property (@(posedge clock) disable iff (reset)
        (cnt_q <= CNT_W'(DEPTH)) && (tail_q == head_q + cnt_q[PTR_W-1:0]));

endmodule

// File: tb/tb_ifu_inst_queue.sv
// -----------------------------------------------------------------------------
// tb_ifu_inst_queue
//
// Self-checking bench for ifu_inst_queue (DEPTH=16). A table of per-cycle
// vectors {flush, in_valid, out_ready, expected in_ready/out_valid/count} is
// applied in a loop; a scoreboard queue holds the entries the queue should
// contain, is pushed on accepted lanes and popped on dequeued lanes, and
// supplies the expected data on every valid decode lane. A random phase,
// a mid-operation reset and (with IFU_INST_QUEUE_PERF_EN) the full-cycle
// counter follow.
// -----------------------------------------------------------------------------
module tb_ifu_inst_queue;

    localparam int DEPTH = 16;
    localparam int AW    = 32;

    logic            clock = 1'b0;
    logic            reset;
    logic            flush;
    logic [3:0]      in_valid;
    logic [3:0]      in_ready;
    logic [3:0]      out_valid;
    logic [3:0]      out_ready;
    logic [31:0]     inst_i [4];
    logic [AW-1:0]   pc_i   [4];
    logic            pred_i [4];
    logic [31:0]     inst_o [4];
    logic [AW-1:0]   pc_o   [4];
    logic            pred_o [4];
    logic [4:0]      count;
`ifdef IFU_INST_QUEUE_PERF_EN
    logic [31:0]     perf_full_cycles;
    logic [31:0]     perf_empty_cycles;
`endif

    ifu_inst_queue #(.DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
        .clock     (clock),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .inst1_i   (inst_i[0]), .inst2_i(inst_i[1]), .inst3_i(inst_i[2]), .inst4_i(inst_i[3]),
        .pc1_i     (pc_i[0]),   .pc2_i(pc_i[1]),     .pc3_i(pc_i[2]),     .pc4_i(pc_i[3]),
        .pred1_i   (pred_i[0]), .pred2_i(pred_i[1]), .pred3_i(pred_i[2]), .pred4_i(pred_i[3]),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .inst1_o   (inst_o[0]), .inst2_o(inst_o[1]), .inst3_o(inst_o[2]), .inst4_o(inst_o[3]),
        .pc1_o     (pc_o[0]),   .pc2_o(pc_o[1]),     .pc3_o(pc_o[2]),     .pc4_o(pc_o[3]),
        .pred1_o   (pred_o[0]), .pred2_o(pred_o[1]), .pred3_o(pred_o[2]), .pred4_o(pred_o[3]),
`ifdef IFU_INST_QUEUE_PERF_EN
        .perf_full_cycles  (perf_full_cycles),
        .perf_empty_cycles (perf_empty_cycles),
`endif
        .count     (count)
    );

    always #5 clock = ~clock;

    // -------------------------------------------------------------------------
    // Checking and scoreboard
    // -------------------------------------------------------------------------
    typedef struct {
        logic [31:0]   inst;
        logic [AW-1:0] pc;
        logic          pred;
    } ent_t;

    typedef struct {
        logic          fl;
        logic [3:0]    iv;
        logic [3:0]    ordy;
        logic [3:0]    exp_ir;
        logic [3:0]    exp_ov;
        int            exp_cnt;
        logic          chk_pc1;
        logic [AW-1:0] exp_pc1;
    } vec_t;

    ent_t          sb [$];
    vec_t          vecs [$];
    logic [AW-1:0] next_pc;
    int            n_checks = 0;
    int            n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic logic [31:0] inst_of(input logic [AW-1:0] pc);
        return {pc[15:0], ~pc[15:0]};
    endfunction

    function automatic logic pred_of(input logic [AW-1:0] pc);
        return ^pc[5:2];
    endfunction

    function automatic int lead(input logic [3:0] v);
        int n = 0;
        while (n < 4 && v[n]) n++;
        return n;
    endfunction

    // One clock cycle: drive at negedge, check handshake and data mid-cycle,
    // then update the scoreboard at the edge and check the new occupancy.
    task automatic step(input logic fl, input logic [3:0] iv, input logic [3:0] ordy,
                        input logic [3:0] exp_ir, input logic [3:0] exp_ov, input int exp_cnt,
                        input logic chk_pc1, input logic [AW-1:0] exp_pc1, input string tag);
        int e;
        int d;
        @(negedge clock);
        flush     = fl;
        in_valid  = iv;
        out_ready = ordy;
        for (int k = 0; k < 4; k++) begin
            pc_i[k]   = next_pc + AW'(4 * k);
            inst_i[k] = inst_of(pc_i[k]);
            pred_i[k] = pred_of(pc_i[k]);
        end
        #1;
        check({tag, " in_ready"},  64'(in_ready),  64'(exp_ir));
        check({tag, " out_valid"}, 64'(out_valid), 64'(exp_ov));
        if (chk_pc1) check({tag, " pc1_o"}, 64'(pc_o[0]), 64'(exp_pc1));
        for (int k = 0; k < 4; k++) begin
            if (exp_ov[k] && k < sb.size()) begin
                check($sformatf("%s pc%0d_o", tag, k + 1),   64'(pc_o[k]),   64'(sb[k].pc));
                check($sformatf("%s inst%0d_o", tag, k + 1), 64'(inst_o[k]), 64'(sb[k].inst));
                check($sformatf("%s pred%0d_o", tag, k + 1), 64'(pred_o[k]), 64'(sb[k].pred));
            end
        end
        e = fl ? 0 : lead(iv & exp_ir);
        d = fl ? 0 : lead(exp_ov & ordy);
        @(posedge clock);
        #1;
        if (fl) begin
            sb.delete();
            next_pc = 32'h8000_0008;   // redirect target
        end else begin
            for (int k = 0; k < d && sb.size() > 0; k++) void'(sb.pop_front());
            for (int k = 0; k < e; k++) begin
                ent_t en;
                en.pc   = next_pc + AW'(4 * k);
                en.inst = inst_of(en.pc);
                en.pred = pred_of(en.pc);
                sb.push_back(en);
            end
            next_pc = next_pc + AW'(4 * e);
        end
        check({tag, " count"}, 64'(count), 64'(exp_cnt));
    endtask

    // Step whose expectations come from the scoreboard occupancy.
    task automatic mstep(input logic fl, input logic [3:0] iv, input logic [3:0] ordy, input string tag);
        int         sz;
        logic [3:0] ir;
        logic [3:0] ov;
        int         c;
        sz = sb.size();
        for (int k = 0; k < 4; k++) begin
            ir[k] = !fl && ((DEPTH - sz) > k);
            ov[k] = !fl && (sz > k);
        end
        c = fl ? 0 : sz + lead(iv & ir) - lead(ov & ordy);
        step(fl, iv, ordy, ir, ov, c, 1'b0, '0, tag);
    endtask

    function automatic vec_t mk(input logic fl, input logic [3:0] iv, input logic [3:0] ordy,
                                input logic [3:0] ir, input logic [3:0] ov, input int c,
                                input logic cp, input logic [AW-1:0] p1);
        vec_t v;
        v.fl = fl; v.iv = iv; v.ordy = ordy; v.exp_ir = ir; v.exp_ov = ov;
        v.exp_cnt = c; v.chk_pc1 = cp; v.exp_pc1 = p1;
        return v;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    // -------------------------------------------------------------------------
    // Test sequence
    // -------------------------------------------------------------------------
    initial begin
        // Vector table: fill, full, partial dequeue, drain, steady state,
        // gapped lanes, flush under traffic, post-flush enqueue and read.
        vecs.push_back(mk(0, 4'b1111, 4'b0000, 4'b1111, 4'b0000,  4, 0, '0));
        vecs.push_back(mk(0, 4'b1111, 4'b0000, 4'b1111, 4'b1111,  8, 1, 32'h8000_0004));
        vecs.push_back(mk(0, 4'b1111, 4'b0000, 4'b1111, 4'b1111, 12, 0, '0));
        vecs.push_back(mk(0, 4'b1111, 4'b0000, 4'b1111, 4'b1111, 16, 0, '0));
        vecs.push_back(mk(0, 4'b1111, 4'b0000, 4'b0000, 4'b1111, 16, 0, '0));
        vecs.push_back(mk(0, 4'b1111, 4'b0011, 4'b0000, 4'b1111, 14, 1, 32'h8000_0004));
        vecs.push_back(mk(0, 4'b1111, 4'b0000, 4'b0011, 4'b1111, 16, 1, 32'h8000_000C));
        vecs.push_back(mk(0, 4'b0000, 4'b1111, 4'b0000, 4'b1111, 12, 0, '0));
        vecs.push_back(mk(0, 4'b0000, 4'b1111, 4'b1111, 4'b1111,  8, 0, '0));
        for (int i = 0; i < 20; i++)
            vecs.push_back(mk(0, 4'b1111, 4'b1111, 4'b1111, 4'b1111, 8, 0, '0));
        vecs.push_back(mk(0, 4'b1011, 4'b0000, 4'b1111, 4'b1111, 10, 0, '0));
        vecs.push_back(mk(1, 4'b1111, 4'b1111, 4'b0000, 4'b0000,  0, 0, '0));
        vecs.push_back(mk(0, 4'b0001, 4'b0000, 4'b1111, 4'b0000,  1, 0, '0));
        vecs.push_back(mk(0, 4'b0000, 4'b0001, 4'b1111, 4'b0001,  0, 1, 32'h8000_0008));
        vecs.push_back(mk(0, 4'b0000, 4'b1111, 4'b1111, 4'b0000,  0, 0, '0));

        // Reset with active-looking inputs: everything must stay quiet.
        reset     = 1'b1;
        flush     = 1'b0;
        in_valid  = 4'b1111;
        out_ready = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            pc_i[k] = '0; inst_i[k] = '0; pred_i[k] = 1'b0;
        end
        repeat (2) @(posedge clock);
        @(negedge clock);
        check("reset in_ready",  64'(in_ready),  64'h0);
        check("reset out_valid", 64'(out_valid), 64'h0);
        check("reset count",     64'(count),     64'h0);
        reset    = 1'b0;
        in_valid = 4'b0000;
        next_pc  = 32'h8000_0004;

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].fl, vecs[i].iv, vecs[i].ordy, vecs[i].exp_ir, vecs[i].exp_ov,
                 vecs[i].exp_cnt, vecs[i].chk_pc1, vecs[i].exp_pc1, $sformatf("vec%0d", i));
        end

        // Random traffic with occasional flushes.
        for (int i = 0; i < 300; i++) begin
            mstep($urandom_range(0, 19) == 0, 4'($urandom), 4'($urandom), $sformatf("rnd%0d", i));
        end

        // Reset in the middle of operation discards the contents.
        mstep(0, 4'b1111, 4'b0000, "pre_rst0");
        mstep(0, 4'b1111, 4'b0000, "pre_rst1");
        @(negedge clock);
        reset     = 1'b1;
        in_valid  = 4'b1111;
        out_ready = 4'b1111;
        #1;
        check("midrst in_ready",  64'(in_ready),  64'h0);
        check("midrst out_valid", 64'(out_valid), 64'h0);
        check("midrst count",     64'(count),     64'h0);
        @(posedge clock);
        #1;
        reset    = 1'b0;
        in_valid = 4'b0000;
        sb.delete();
        next_pc  = 32'h9000_0000;
        mstep(0, 4'b0000, 4'b1111, "post_rst");

`ifdef IFU_INST_QUEUE_PERF_EN
        // Reset cleared the counters; fill without hitting full, then hold
        // full with fetch pressure for five cycles.
        for (int i = 0; i < 4; i++) mstep(0, 4'b1111, 4'b0000, $sformatf("pfill%0d", i));
        for (int i = 0; i < 5; i++) mstep(0, 4'b1111, 4'b0000, $sformatf("pfull%0d", i));
        check("perf_full_cycles", 64'(perf_full_cycles), 64'd5);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
